// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter giving ALU results priority over buffered load results, with a busy scoreboard
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [4:0]                   alu_rd,
  input  logic [31:0]                  alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [4:0]                   mem_rd,
  input  logic [31:0]                  mem_data,
  input  logic                         issue_valid,
  input  logic [4:0]                   issue_rd,
  output logic                         RegWrite,
  output logic [4:0]                   WriteRegister,
  output logic [31:0]                  WriteData,
  output logic [31:0]                  busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [36:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   busy_q, busy_d;
  logic          push, pop, sel;
  logic [36:0]   head;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data, clr, set;
  assign mem_ready     = cnt_q < CW'(FIFO_DEPTH);
  assign RegWrite      = we_q;
  assign WriteRegister = wa_q;
  assign WriteData     = wd_q;
  assign busy          = busy_q;
  assign fifo_count    = cnt_q;
  always_comb begin
    push     = mem_valid & mem_ready;
    pop      = ~alu_valid & (cnt_q != '0);
    sel      = alu_valid | pop;
    head     = fifo_q[rd_q];
    sel_rd   = alu_valid ? alu_rd : head[36:32];
    sel_data = alu_valid ? alu_data : head[31:0];
    // a write to r0 is consumed but never strobed
    we_d     = sel & (sel_rd != 5'd0);
    wa_d     = we_d ? sel_rd : wa_q;
    wd_d     = we_d ? sel_data : wd_q;
    clr      = sel ? 32'd1 << sel_rd : '0;
    set      = issue_valid ? 32'd1 << issue_rd : '0;
    busy_d   = ((busy_q & ~clr) | set) & ~32'd1;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= {mem_rd, mem_data};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      wr_q   <= push ? wr_q + AW'(1) : wr_q;
      rd_q   <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic against a queue-based writeback model
module tb_wb_arbiter;
  localparam int D = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  alu_rd = '0, mem_rd = '0, issue_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        mem_ready, RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData, busy;
  logic [2:0]  fifo_count;
  int checks = 0, failures = 0;
  logic [36:0] mq[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_busy;

  wb_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_busy = '0;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
  endtask

  // Applies the writeback rules to the inputs presented for the coming edge, then advances one cycle.
  task automatic edge_step();
    logic [36:0] w;
    bit hw, push;
    w = '0;
    hw = 1'b0;
    push = mem_valid && (mq.size() < D);
    if (alu_valid) begin w = {alu_rd, alu_data}; hw = 1'b1; end
    else if (mq.size() > 0) begin w = mq.pop_front(); hw = 1'b1; end
    if (push) mq.push_back({mem_rd, mem_data});
    m_we = hw && (w[36:32] != 5'd0);
    if (m_we) begin m_wa = w[36:32]; m_wd = w[31:0]; end
    if (hw) m_busy[w[36:32]] = 1'b0;
    if (issue_valid) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #3;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", RegWrite); end
    checks++; if (WriteRegister !== 5'd0) begin failures++; $display("FAIL reset_wa got=%0d exp=0", WriteRegister); end
    checks++; if (WriteData !== 32'd0) begin failures++; $display("FAIL reset_wd got=%0h exp=0", WriteData); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", mem_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_alu_write();
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h0000_00AA;
    edge_step();
    idle();
    checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL alu_we got=%0b exp=1", RegWrite); end
    checks++; if (WriteRegister !== 5'd8) begin failures++; $display("FAIL alu_wa got=%0d exp=8", WriteRegister); end
    checks++; if (WriteData !== 32'hAA) begin failures++; $display("FAIL alu_wd got=%0h exp=aa", WriteData); end
    edge_step();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL idle_we got=%0b exp=0", RegWrite); end
    checks++; if (WriteData !== 32'hAA) begin failures++; $display("FAIL hold_wd got=%0h exp=aa", WriteData); end
  endtask

  task automatic test_load_order();
    int peak = 0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = (i < 3); mem_rd = 5'(9 + i); mem_data = 32'(i + 1);
      edge_step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      checks++; if (RegWrite !== (i != 0)) begin failures++; $display("FAIL load_we[%0d] got=%0b exp=%0b", i, RegWrite, i != 0); end
      if (i != 0) begin
        checks++; if (WriteRegister !== 5'(8 + i)) begin failures++; $display("FAIL load_wa[%0d] got=%0d exp=%0d", i, WriteRegister, 8 + i); end
        checks++; if (WriteData !== 32'(i)) begin failures++; $display("FAIL load_wd[%0d] got=%0h exp=%0h", i, WriteData, i); end
      end
      checks++; if (fifo_count !== ((i < 3) ? 3'd1 : 3'd0)) begin failures++; $display("FAIL load_count[%0d] got=%0d exp=%0d", i, fifo_count, (i < 3) ? 1 : 0); end
    end
    idle();
    checks++; if (peak != 1) begin failures++; $display("FAIL load_peak got=%0d exp=1", peak); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(i);
      mem_valid = (i < 5); mem_rd = 5'(16 + i); mem_data = 32'(100 + i);
      #1;
      checks++; if (mem_ready !== (i < 4)) begin failures++; $display("FAIL full_ready[%0d] got=%0b exp=%0b", i, mem_ready, i < 4); end
      edge_step();
    end
    idle();
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", mem_ready); end
    for (int k = 0; k < 5; k++) begin
      edge_step();
      checks++; if (RegWrite !== (k < 4)) begin failures++; $display("FAIL drain_we[%0d] got=%0b exp=%0b", k, RegWrite, k < 4); end
      if (k < 4) begin
        checks++; if (WriteRegister !== 5'(16 + k) || WriteData !== 32'(100 + k)) begin failures++; $display("FAIL drain_w[%0d] got=%0d/%0d exp=%0d/%0d", k, WriteRegister, WriteData, 16 + k, 100 + k); end
        checks++; if (fifo_count !== 3'(3 - k)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, fifo_count, 3 - k); end
      end
    end
  endtask

  task automatic test_busy();
    issue_valid = 1'b1; issue_rd = 5'd12;
    edge_step();
    issue_valid = 1'b0;
    checks++; if (busy[12] !== 1'b1) begin failures++; $display("FAIL busy_n got=%0b exp=1", busy[12]); end
    edge_step();
    checks++; if (busy[12] !== 1'b1) begin failures++; $display("FAIL busy_n1 got=%0b exp=1", busy[12]); end
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h55;
    edge_step();
    mem_valid = 1'b0;
    checks++; if (busy[12] !== 1'b1) begin failures++; $display("FAIL busy_n2 got=%0b exp=1", busy[12]); end
    edge_step();
    checks++; if (busy[12] !== 1'b0) begin failures++; $display("FAIL busy_n3 got=%0b exp=0", busy[12]); end
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd12 || WriteData !== 32'h55) begin failures++; $display("FAIL busy_ld got=%0b/%0d/%0h exp=1/12/55", RegWrite, WriteRegister, WriteData); end
    issue_valid = 1'b1; issue_rd = 5'd12; alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h77;
    edge_step();
    issue_valid = 1'b0;
    checks++; if (busy[12] !== 1'b1) begin failures++; $display("FAIL set_wins got=%0b exp=1", busy[12]); end
    alu_data = 32'h88;
    edge_step();
    idle();
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL busy_clr got=%0h exp=0", busy); end
  endtask

  task automatic test_reg0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD; issue_valid = 1'b1; issue_rd = 5'd0;
    edge_step();
    idle();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL r0_we got=%0b exp=0", RegWrite); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL r0_busy got=%0h exp=0", busy); end
    checks++; if (WriteData !== 32'h88) begin failures++; $display("FAIL r0_wd got=%0h exp=88", WriteData); end
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBEEF;
    edge_step();
    idle();
    edge_step();
    checks++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL r0_ld got=%0b/%0d exp=0/0", RegWrite, fifo_count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(i);
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'(200 + i);
      issue_valid = (i == 0); issue_rd = 5'd9;
      edge_step();
    end
    idle();
    checks++; if (fifo_count !== 3'd3 || busy[9] !== 1'b1) begin failures++; $display("FAIL pre_rst got=%0d/%0b exp=3/1", fifo_count, busy[9]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0) begin failures++; $display("FAIL mid_rst_w got=%0b/%0d/%0h exp=0/0/0", RegWrite, WriteRegister, WriteData); end
    checks++; if (busy !== 32'd0 || fifo_count !== 3'd0 || mem_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_st got=%0h/%0d/%0b exp=0/0/1", busy, fifo_count, mem_ready); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edge_step();
      checks++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL post_rst[%0d] got=%0b/%0d exp=0/0", k, RegWrite, fifo_count); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      alu_valid = (n < 200) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
      alu_rd = 5'($urandom); alu_data = $urandom;
      mem_valid = $urandom % 2; mem_rd = 5'($urandom); mem_data = $urandom;
      issue_valid = $urandom % 3 == 0; issue_rd = 5'($urandom);
      checks++; if (mem_ready !== (mq.size() < D)) begin failures++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", n, mem_ready, mq.size() < D); end
      edge_step();
      checks++; if (RegWrite !== m_we) begin failures++; $display("FAIL rnd_we[%0d] got=%0b exp=%0b", n, RegWrite, m_we); end
      checks++; if (WriteRegister !== m_wa || WriteData !== m_wd) begin failures++; $display("FAIL rnd_w[%0d] got=%0d/%0h exp=%0d/%0h", n, WriteRegister, WriteData, m_wa, m_wd); end
      checks++; if (busy !== m_busy) begin failures++; $display("FAIL rnd_busy[%0d] got=%0h exp=%0h", n, busy, m_busy); end
      checks++; if (int'(fifo_count) != mq.size()) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, fifo_count, mq.size()); end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_write();
    test_load_order();
    test_full();
    test_busy();
    test_reg0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of memory-result buffer entries (power of 2, 2..16).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 alu_valid  input  1  single-cycle ALU result present this cycle; always accepted.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 mem_valid  input  1  load result offered.
REQ-008 mem_ready  output  1  buffer can accept a load result (combinational: count < FIFO_DEPTH).
REQ-009 mem_rd  input  5  load destination register.
REQ-010 mem_data  input  32  load data.
REQ-011 issue_valid  input  1  an instruction with a destination register issues this cycle.
REQ-012 issue_rd  input  5  destination register of the issuing instruction.
REQ-013 RegWrite  output  1  registered write strobe to the register file.
REQ-014 WriteRegister  output  5  registered write address.
REQ-015 WriteData  output  32  registered write data.
REQ-016 busy  output  32  registered scoreboard; bit n = register n has a pending write.
REQ-017 fifo_count  output  log2(FIFO_DEPTH)+1  registered number of buffered load results.

Function
REQ-018 Load accepted at a rising edge when mem_valid and mem_ready are both 1; entry {mem_rd, mem_data} is appended to the FIFO tail.
REQ-019 Arbitration per edge: alu_valid=1 -> ALU result written; else count>0 -> FIFO head written and popped; else no write.
REQ-020 The selected write appears on RegWrite/WriteRegister/WriteData in the cycle after the edge (one-cycle latency); RegWrite=0 in cycles with no write.
REQ-021 No bypass: a load enqueued into an empty FIFO is written no earlier than the following edge (minimum two-edge latency).
REQ-022 Simultaneous enqueue and dequeue at one edge leaves fifo_count unchanged; FIFO order is strictly first-in first-out.
REQ-023 Full: mem_ready=0; mem_valid is ignored; no entry is overwritten and fifo_count never exceeds FIFO_DEPTH.
REQ-024 Empty: no pop occurs and no spurious RegWrite is produced.
REQ-025 Pointers wrap modulo FIFO_DEPTH without data loss.
REQ-026 Register 0: a selected write with rd=0 is consumed (popped or dropped) but RegWrite stays 0; busy[0] is always 0; issue_rd=0 sets nothing.
REQ-027 issue_valid with issue_rd=n (n≠0) sets busy[n] at the edge.
REQ-028 A write selected for register n clears busy[n] at the same edge.
REQ-029 Set and clear of the same register at one edge: set wins (busy stays 1).
REQ-030 WriteData is held stable when RegWrite=0; register-file contents are not affected.

Reset
REQ-031 rst=1 immediately forces RegWrite=0, WriteRegister=0, WriteData=0, busy=0, fifo_count=0, FIFO pointers=0, regardless of clk.
REQ-032 Reset asserted mid-operation discards all buffered loads and pending busy bits; after release, mem_ready=1 and the first edge behaves as from power-up.

Verification
REQ-033 alu_valid=1, alu_rd=8, alu_data=0x0000_00AA at edge N -> cycle after N: RegWrite=1, WriteRegister=8, WriteData=0xAA.
REQ-034 Loads rd 9/10/11 data 1/2/3 on consecutive edges, alu_valid=0 -> writes to 9, 10, 11 in order, each one edge after its enqueue edge +1; fifo_count peaks at 1.
REQ-035 alu_valid=1 held 6 cycles while 5 loads are offered -> 4 accepted, mem_ready=0 after the 4th, fifo_count=4; loads drain in order once alu_valid drops.
REQ-036 issue_valid rd=12 at edge N; load rd=12 written at edge N+3 -> busy[12]=1 for cycles N..N+2, 0 after N+3; issue rd=12 coincident with a write to 12 -> busy[12] stays 1.
REQ-037 alu_valid=1, alu_rd=0 -> RegWrite stays 0, busy[0]=0.
REQ-038 3 loads buffered, busy[9]=1, rst pulsed between edges -> all outputs 0 at once, fifo_count=0, mem_ready=1, no buffered load ever written.
